// File: rtl/ptw_mem_arbiter_if.sv
// rtl/ptw_mem_arbiter_if.sv - PTW memory arbiter bundle: IF/LS walk requests, shared memory port, status.
interface ptw_mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_rvalid_o;
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_rdata_o;
  logic        ls_rvalid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        flush_i;
  logic        busy_o;
  logic        owner_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_addr_i,
    input  mem_rdata_i, mem_rvalid_i, flush_i,
    output if_rdata_o, if_rvalid_o, ls_rdata_o, ls_rvalid_o,
    output mem_req_o, mem_addr_o, busy_o, owner_o
  );

  // Environment side: MMUs, memory and flush source.
  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_addr_i,
    output mem_rdata_i, mem_rvalid_i, flush_i,
    input  if_rdata_o, if_rvalid_o, ls_rdata_o, ls_rvalid_o,
    input  mem_req_o, mem_addr_o, busy_o, owner_o
  );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// rtl/ptw_mem_arbiter.sv - IF/LS page-table-walk arbiter onto one memory read port.
// Define PTW_ARB_RR_EN for round-robin tie-break; default build gives ties to LS.
module ptw_mem_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  ptw_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        mem_req_q;
  logic [31:0] addr_q;
  logic        last_ls_q;
  logic        granted_q;
  logic        grant_vld;
  logic        grant_ls;
  logic        if_rv;
  logic        ls_rv;

  always_comb begin
    grant_vld = 1'b0;
    grant_ls  = 1'b0;
    if (state_q == IDLE && !bus.flush_i) begin
      grant_vld = bus.if_req_i | bus.ls_req_i;
      if (bus.if_req_i && bus.ls_req_i) begin
`ifdef PTW_ARB_RR_EN
        grant_ls = ~last_ls_q;
`else
        grant_ls = 1'b1;
`endif
      end else begin
        grant_ls = bus.ls_req_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) state_d = grant_ls ? BUSY_LS : BUSY_IF;
      end
      BUSY_IF, BUSY_LS: begin
        // A flush that lands with the data just drops it; otherwise wait it out in DRAIN.
        if (bus.mem_rvalid_i)  state_d = IDLE;
        else if (bus.flush_i)  state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= 32'h0;
      last_ls_q <= 1'b1;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= grant_vld;
      if (grant_vld) begin
        addr_q    <= grant_ls ? bus.ls_addr_i : bus.if_addr_i;
        last_ls_q <= grant_ls;
        granted_q <= 1'b1;
      end
    end
  end

  assign if_rv = (state_q == BUSY_IF) && bus.mem_rvalid_i && !bus.flush_i;
  assign ls_rv = (state_q == BUSY_LS) && bus.mem_rvalid_i && !bus.flush_i;

  assign bus.if_rvalid_o = if_rv;
  assign bus.ls_rvalid_o = ls_rv;
  assign bus.if_rdata_o  = {32{if_rv}} & bus.mem_rdata_i;
  assign bus.ls_rdata_o  = {32{ls_rv}} & bus.mem_rdata_i;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.busy_o      = (state_q != IDLE);
  // The last-grant register resets to LS but owner reads 0 until the first grant.
  assign bus.owner_o     = last_ls_q & granted_q;

endmodule

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 The port list SHALL be as follows (name  direction  width  meaning).
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF-side MMU page-table read request (level).
- if_addr_i  in  32  IF-side PTE physical address.
- if_rdata_o  out  32  PTE data to IF-side MMU.
- if_rvalid_o  out  1  IF-side response valid (1-cycle pulse).
- ls_req_i  in  1  LS-side MMU page-table read request (level).
- ls_addr_i  in  32  LS-side PTE physical address.
- ls_rdata_o  out  32  PTE data to LS-side MMU.
- ls_rvalid_o  out  1  LS-side response valid (1-cycle pulse).
- mem_req_o  out  1  shared memory-port request (1-cycle pulse).
- mem_addr_o  out  32  shared memory-port address.
- mem_rdata_i  in  32  shared memory-port read data.
- mem_rvalid_i  in  1  shared memory-port read data valid.
- flush_i  in  1  MMU flush (sfence.vma / satp write); abandons the in-flight walk read.
- busy_o  out  1  arbiter not IDLE.
- owner_o  out  1  current grant: 0 = IF, 1 = LS; valid while busy_o = 1.

Function
REQ-002 The FSM SHALL have four states: IDLE, BUSY_IF, BUSY_LS, DRAIN.
REQ-003 In IDLE with flush_i = 0 and at least one req_i high, the arbiter SHALL grant one requester, latch its address into mem_addr_o, and enter BUSY_IF or BUSY_LS on the next edge.
REQ-004 mem_req_o SHALL be high for exactly the first cycle of BUSY_IF or BUSY_LS; downstream holds the transaction until mem_rvalid_i.
REQ-005 mem_addr_o SHALL stay stable from grant until the state returns to IDLE.
REQ-006 In BUSY_x, when mem_rvalid_i = 1 and flush_i = 0, x_rdata_o SHALL equal mem_rdata_i and x_rvalid_o = 1 in that same cycle (combinational route); the next state SHALL be IDLE.
REQ-007 The non-owner rvalid_o SHALL always be 0; rdata_o outputs SHALL be 0 when the matching rvalid_o = 0.
REQ-008 req_i SHALL be sampled only in IDLE. A requester deasserts req_i no later than the cycle after its rvalid_o; there is one mandatory IDLE bubble between consecutive grants.
REQ-009 flush_i in BUSY_x with mem_rvalid_i = 0 SHALL move to DRAIN; DRAIN waits for mem_rvalid_i, suppresses all rvalid_o, then enters IDLE.
REQ-010 flush_i in BUSY_x coincident with mem_rvalid_i SHALL suppress rvalid_o and enter IDLE directly.
REQ-011 flush_i in IDLE SHALL block any grant that cycle; flush_i in DRAIN has no further effect.
REQ-012 mem_rvalid_i in IDLE SHALL be ignored (no rvalid_o, no state change).
REQ-013 busy_o SHALL equal (state != IDLE); owner_o SHALL hold the last grant.

Reset
REQ-014 rst_n low SHALL asynchronously force: state IDLE, mem_req_o 0, mem_addr_o 0, owner_o 0, busy_o 0, both rvalid_o 0, both rdata_o 0, last-grant register = LS.
REQ-015 Reset asserted during BUSY or DRAIN SHALL abandon the transaction; a late mem_rvalid_i after reset SHALL be ignored per REQ-012.

Configuration
REQ-016 With macro PTW_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin: the grant goes to the requester not granted last. Reset state makes IF win the first tie.
REQ-017 Without PTW_ARB_RR_EN, simultaneous requests SHALL be granted to LS (fixed priority); the last-grant register is still updated but not used.

Verification
REQ-018 Single IF request: if_req_i = 1, if_addr_i = 0x8000_1000; mem returns 0x2000_0401 after 3 cycles -> mem_req_o pulses once with addr 0x8000_1000; if_rvalid_o = 1 with data 0x2000_0401 in the same cycle; ls_rvalid_o never set.
REQ-019 Simultaneous requests after reset (IF 0x100, LS 0x200), held through two transactions -> with PTW_ARB_RR_EN: IF, then LS; without: LS, then IF; one IDLE cycle between the grants.
REQ-020 Flush mid-walk: LS granted, flush_i pulsed one cycle before mem_rvalid_i (data 0xDEAD_BEEF) -> state enters DRAIN; ls_rvalid_o stays 0; busy_o drops the cycle after rvalid.
REQ-021 Flush coincident with mem_rvalid_i in BUSY_IF -> if_rvalid_o = 0; IDLE on the next cycle; no DRAIN visit.
REQ-022 rst_n asserted while BUSY_LS, released, then a stray mem_rvalid_i -> all outputs at reset values; no rvalid_o pulse; a new IF request afterwards is served normally.
